// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

   localparam int INSTR_BYTES = 4;
   localparam int DWORD_BYTES = 8;

   typedef enum logic [1:0] {
      REQ   = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2,
      IDLE  = 2'd3
   } fetch_state_e;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - memory bus, redirect and decoder handshake bundle
interface instr_fetch_if;

   logic        bus_req_valid;
   logic [63:0] bus_req_addr;
   logic        bus_req_ready;
   logic        bus_resp_valid;
   logic [63:0] bus_resp_data;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        instr_valid;
   logic [31:0] instruction;
   logic [63:0] cur_pc;
   logic        decode_ready;

   modport master (
      output bus_req_valid, bus_req_addr,
      input  bus_req_ready, bus_resp_valid, bus_resp_data,
      input  redirect_valid, redirect_pc,
      output instr_valid, instruction, cur_pc,
      input  decode_ready
   );

   modport slave (
      input  bus_req_valid, bus_req_addr,
      output bus_req_ready, bus_resp_valid, bus_resp_data,
      output redirect_valid, redirect_pc,
      input  instr_valid, instruction, cur_pc,
      output decode_ready
   );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - instruction buffer with 2-wide push, 1-wide pop and flush
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       resetn_i,
   input  logic                       flush_i,
   input  logic                       push0_i,
   input  logic                       push1_i,
   input  fetch_entry_t               push0_data_i,
   input  fetch_entry_t               push1_data_i,
   input  logic                       pop_i,
   output fetch_entry_t               head_o,
   output logic                       head_valid_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t    mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q;
   logic [AW-1:0]   rd_ptr_q;
   logic [CW-1:0]   count_q;

   // push1 is only ever used together with push0, landing in the following slot
   always_ff @(posedge clk) begin
      if (!resetn_i || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push0_i) mem_q[wr_ptr_q] <= push0_data_i;
         if (push1_i) mem_q[wr_ptr_q + AW'(1)] <= push1_data_i;
         wr_ptr_q <= wr_ptr_q + AW'(push0_i) + AW'(push1_i);
         if (pop_i) rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q  <= count_q + CW'(push0_i) + CW'(push1_i) - CW'(pop_i);
      end
   end

   assign head_o       = mem_q[rd_ptr_q];
   assign head_valid_o = (count_q != '0);
   assign count_o      = count_q;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch FSM: doubleword reads, split into two instructions, redirect flush
module instr_fetch
   import fetch_pkg::*;
#(
   parameter logic [63:0] ENTRY_PC   = 64'h0,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   instr_fetch_if.master bus
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int OW = CW + 1;

   fetch_state_e  state_q, state_d;
   logic [63:0]   fetch_pc_q, fetch_pc_d;
   logic          run_q;

   logic [CW-1:0] fifo_count;
   logic [OW-1:0] occ_next;
   fetch_entry_t  head;
   fetch_entry_t  push0_entry, push1_entry;
   logic          head_valid;
   logic          req_fire, resp_take, pop, push0, push1, flush;

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk          (clk),
      .resetn_i     (reset),
      .flush_i      (flush),
      .push0_i      (push0),
      .push1_i      (push1),
      .push0_data_i (push0_entry),
      .push1_data_i (push1_entry),
      .pop_i        (pop),
      .head_o       (head),
      .head_valid_o (head_valid),
      .count_o      (fifo_count)
   );

   assign req_fire  = bus.bus_req_valid && bus.bus_req_ready;
   assign pop       = head_valid && bus.decode_ready;
   assign flush     = bus.redirect_valid;
   assign resp_take = (state_q == WAIT) && bus.bus_resp_valid && !bus.redirect_valid;
   assign push0     = resp_take;
   assign push1     = resp_take && !fetch_pc_q[2];
   assign occ_next  = {1'b0, fetch_count_ext()} + OW'(push0) + OW'(push1) - OW'(pop);

   function automatic logic [CW-1:0] fetch_count_ext();
      return fifo_count;
   endfunction

   // An odd-word PC means the low half of the doubleword precedes the target
   always_comb begin
      push0_entry.pc    = fetch_pc_q;
      push0_entry.instr = fetch_pc_q[2] ? bus.bus_resp_data[63:32] : bus.bus_resp_data[31:0];
      push1_entry.pc    = fetch_pc_q + 64'(INSTR_BYTES);
      push1_entry.instr = bus.bus_resp_data[63:32];
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      if (bus.redirect_valid) begin
         fetch_pc_d = bus.redirect_pc;
         case (state_q)
            WAIT, DRAIN: state_d = bus.bus_resp_valid ? REQ : DRAIN;
            REQ:         state_d = req_fire ? DRAIN : REQ;
            default:     state_d = REQ;
         endcase
      end else begin
         case (state_q)
            REQ:   if (req_fire) state_d = WAIT;
            WAIT:  if (bus.bus_resp_valid) begin
                      fetch_pc_d = fetch_pc_q + (fetch_pc_q[2] ? 64'(INSTR_BYTES) : 64'(DWORD_BYTES));
                      state_d    = (occ_next <= OW'(FIFO_DEPTH - 2)) ? REQ : IDLE;
                   end
            DRAIN: if (bus.bus_resp_valid) state_d = REQ;
            default: if (fifo_count <= CW'(FIFO_DEPTH - 2)) state_d = REQ;
         endcase
      end
   end

   // run_q keeps the request line quiet until the first edge out of reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= REQ;
         fetch_pc_q <= ENTRY_PC;
         run_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         run_q      <= 1'b1;
      end
   end

   assign bus.bus_req_valid = run_q && (state_q == REQ);
   assign bus.bus_req_addr  = bus.bus_req_valid ? {fetch_pc_q[63:3], 3'b000} : 64'h0;
   assign bus.instr_valid   = head_valid;
   assign bus.instruction   = head_valid ? head.instr : 32'h0;
   assign bus.cur_pc        = head_valid ? head.pc : 64'h0;

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (reset && bus.bus_resp_valid && (state_q != WAIT) && (state_q != DRAIN))
         $error("instr_fetch: read response with no outstanding request");
   end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch
module tb_instr_fetch;
   import fetch_pkg::*;

   localparam logic [63:0] ENTRY = 64'h1000;

   logic clk = 1'b0;
   logic reset;

   instr_fetch_if ifc();

   instr_fetch #(.ENTRY_PC(ENTRY), .FIFO_DEPTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc)
   );

   always #5 clk = ~clk;

   int n_checks   = 0;
   int n_fail     = 0;
   int n_consumed = 0;
   int n_req      = 0;
   int cyc        = 0;
   int mem_lat    = 1;

   fetch_entry_t exp_q[$];
   logic [63:0]  pend_addr[$];
   int           pend_due[$];

   function automatic logic [31:0] instr_at(input logic [63:0] pc);
      if (pc == 64'h1000) return 32'h0000_0013;
      if (pc == 64'h1004) return 32'h0050_0093;
      return pc[31:0] ^ pc[63:32] ^ 32'hA5A5_0000;
   endfunction

   // memory: one response per accepted request, mem_lat cycles after acceptance
   always @(posedge clk) begin
      logic        acc;
      logic        rst_s;
      logic [63:0] a;
      acc   = ifc.bus_req_valid && ifc.bus_req_ready;
      a     = ifc.bus_req_addr;
      rst_s = reset;
      cyc++;
      #1;
      if (!rst_s) begin
         pend_addr.delete();
         pend_due.delete();
      end else if (acc) begin
         pend_addr.push_back(a);
         pend_due.push_back(cyc + mem_lat - 1);
         n_req++;
      end
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
         ifc.bus_resp_valid = 1'b1;
         ifc.bus_resp_data  = {instr_at(pend_addr[0] + 64'd4), instr_at(pend_addr[0])};
         void'(pend_due.pop_front());
         void'(pend_addr.pop_front());
      end else begin
         ifc.bus_resp_valid = 1'b0;
         ifc.bus_resp_data  = 64'h0;
      end
   end

   // scoreboard: every instruction the decoder takes must match the head of exp_q
   always @(negedge clk) begin
      fetch_entry_t e;
      if (reset === 1'b1 && ifc.instr_valid === 1'b1 && ifc.decode_ready === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_underflow got pc=%h instr=%h want none", ifc.cur_pc, ifc.instruction);
         end else begin
            e = exp_q.pop_front();
            if (ifc.cur_pc !== e.pc || ifc.instruction !== e.instr) begin
               n_fail++;
               $display("FAIL sb_instr got pc=%h instr=%h want pc=%h instr=%h",
                        ifc.cur_pc, ifc.instruction, e.pc, e.instr);
            end
         end
         n_consumed++;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [63:0] start, input int n);
      fetch_entry_t e;
      for (int i = 0; i < n; i++) begin
         e.pc    = start + 64'(4 * i);
         e.instr = instr_at(e.pc);
         exp_q.push_back(e);
      end
   endtask

   task automatic apply_reset(input int nexp);
      ifc.decode_ready   = 1'b0;
      ifc.redirect_valid = 1'b0;
      reset = 1'b0;
      repeat (2) tick();
      exp_q.delete();
      push_exp(ENTRY, nexp);
      reset = 1'b1;
      tick();
   endtask

   task automatic do_redirect(input logic [63:0] pc, input int nexp);
      ifc.redirect_valid = 1'b1;
      ifc.redirect_pc    = pc;
      exp_q.delete();
      push_exp(pc, nexp);
      tick();
      ifc.redirect_valid = 1'b0;
   endtask

   task automatic consume_until(input int target);
      ifc.decode_ready = 1'b1;
      for (int i = 0; i < 200 && n_consumed < target; i++) tick();
      ifc.decode_ready = 1'b0;
      n_checks++;
      if (n_consumed != target) begin
         n_fail++;
         $display("FAIL consume_count got=%0d want=%0d", n_consumed, target);
      end
   endtask

   task automatic test_reset();
      int base, bad, t0;
      ifc.decode_ready = 1'b0; ifc.redirect_valid = 1'b0; ifc.redirect_pc = 64'h0;
      ifc.bus_req_ready = 1'b1; mem_lat = 1;
      reset = 1'b0;
      repeat (3) tick();
      n_checks++;
      if (ifc.bus_req_valid !== 1'b0 || ifc.bus_req_addr !== 64'h0) begin
         n_fail++;
         $display("FAIL reset_req got valid=%b addr=%h want valid=0 addr=0", ifc.bus_req_valid, ifc.bus_req_addr);
      end
      n_checks++;
      if (ifc.instr_valid !== 1'b0 || ifc.instruction !== 32'h0 || ifc.cur_pc !== 64'h0) begin
         n_fail++;
         $display("FAIL reset_decode got valid=%b instr=%h pc=%h want 0 0 0", ifc.instr_valid, ifc.instruction, ifc.cur_pc);
      end
      base = n_consumed;
      exp_q.delete();
      push_exp(ENTRY, 8);
      reset = 1'b1;
      tick();
      n_checks++;
      if (ifc.bus_req_valid !== 1'b1 || ifc.bus_req_addr !== ENTRY) begin
         n_fail++;
         $display("FAIL first_req got valid=%b addr=%h want valid=1 addr=%h", ifc.bus_req_valid, ifc.bus_req_addr, ENTRY);
      end
      ifc.decode_ready = 1'b1;
      bad = 0;
      for (int i = 0; i < 10 && ifc.instr_valid !== 1'b1; i++) begin
         if (ifc.instruction !== 32'h0) bad++;
         tick();
      end
      t0 = cyc;
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL instr_zero_before_valid got=%0d nonzero cycles want=0", bad);
      end
      n_checks++;
      if (ifc.instr_valid !== 1'b1 || ifc.cur_pc !== ENTRY || ifc.instruction !== 32'h0000_0013) begin
         n_fail++;
         $display("FAIL first_instr got v=%b pc=%h instr=%h want v=1 pc=%h instr=00000013",
                  ifc.instr_valid, ifc.cur_pc, ifc.instruction, ENTRY);
      end
      tick();
      n_checks++;
      if (ifc.instr_valid !== 1'b1 || ifc.cur_pc !== 64'h1004 || ifc.instruction !== 32'h0050_0093) begin
         n_fail++;
         $display("FAIL second_instr got v=%b pc=%h instr=%h want v=1 pc=1004 instr=00500093",
                  ifc.instr_valid, ifc.cur_pc, ifc.instruction);
      end
      consume_until(base + 8);
      n_checks++;
      if (cyc - t0 != 8) begin
         n_fail++;
         $display("FAIL throughput got=%0d cycles want=8", cyc - t0);
      end
   endtask

   task automatic test_redirect_idle();
      int base;
      repeat (6) tick();
      base = n_consumed;
      do_redirect(64'h2004, 6);
      n_checks++;
      if (ifc.instr_valid !== 1'b0 || ifc.bus_req_valid !== 1'b1 || ifc.bus_req_addr !== 64'h2000) begin
         n_fail++;
         $display("FAIL redir_idle_req got v=%b req=%b addr=%h want v=0 req=1 addr=2000",
                  ifc.instr_valid, ifc.bus_req_valid, ifc.bus_req_addr);
      end
      for (int i = 0; i < 10 && ifc.instr_valid !== 1'b1; i++) tick();
      n_checks++;
      if (ifc.instr_valid !== 1'b1 || ifc.cur_pc !== 64'h2004 || ifc.instruction !== instr_at(64'h2004)) begin
         n_fail++;
         $display("FAIL redir_idle_head got v=%b pc=%h instr=%h want v=1 pc=2004 instr=%h",
                  ifc.instr_valid, ifc.cur_pc, ifc.instruction, instr_at(64'h2004));
      end
      n_checks++;
      if (ifc.bus_req_valid !== 1'b1 || ifc.bus_req_addr !== 64'h2008) begin
         n_fail++;
         $display("FAIL redir_idle_next got req=%b addr=%h want req=1 addr=2008", ifc.bus_req_valid, ifc.bus_req_addr);
      end
      consume_until(base + 6);
   endtask

   task automatic test_redirect_wait();
      int base;
      bit found;
      mem_lat = 3; ifc.bus_req_ready = 1'b1;
      apply_reset(0);
      found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (ifc.bus_req_valid === 1'b1 && ifc.bus_req_addr === 64'h1008) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL wait_req_1008 got none want addr=1008");
      end
      tick();
      base = n_consumed;
      do_redirect(64'h3000, 4);
      n_checks++;
      if (ifc.instr_valid !== 1'b0 || dut.fifo_count !== '0 || ifc.bus_req_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL redir_wait_flush got v=%b count=%0d req=%b want v=0 count=0 req=0",
                  ifc.instr_valid, dut.fifo_count, ifc.bus_req_valid);
      end
      for (int i = 0; i < 20 && ifc.instr_valid !== 1'b1; i++) tick();
      n_checks++;
      if (ifc.instr_valid !== 1'b1 || ifc.cur_pc !== 64'h3000) begin
         n_fail++;
         $display("FAIL redir_wait_first got v=%b pc=%h want v=1 pc=3000", ifc.instr_valid, ifc.cur_pc);
      end
      consume_until(base + 4);
   endtask

   task automatic test_backpressure();
      int r0, bad;
      mem_lat = 1; ifc.bus_req_ready = 1'b1;
      apply_reset(8);
      r0 = n_req;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (ifc.instr_valid === 1'b1 && (ifc.cur_pc !== ENTRY || ifc.instruction !== 32'h0000_0013)) bad++;
      end
      n_checks++;
      if (n_req - r0 != 2) begin
         n_fail++;
         $display("FAIL bp_req_count got=%0d want=2", n_req - r0);
      end
      n_checks++;
      if (bad != 0 || ifc.instr_valid !== 1'b1 || ifc.bus_req_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_hold got bad=%0d v=%b req=%b want bad=0 v=1 req=0", bad, ifc.instr_valid, ifc.bus_req_valid);
      end
      ifc.decode_ready = 1'b1;
      tick();
      ifc.decode_ready = 1'b0;
      n_checks++;
      if (ifc.bus_req_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_one_free got req=%b want=0", ifc.bus_req_valid);
      end
      ifc.decode_ready = 1'b1;
      tick();
      ifc.decode_ready = 1'b0;
      n_checks++;
      if (ifc.bus_req_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_idle_cycle got req=%b want=0", ifc.bus_req_valid);
      end
      tick();
      n_checks++;
      if (ifc.bus_req_valid !== 1'b1 || ifc.bus_req_addr !== 64'h1010) begin
         n_fail++;
         $display("FAIL bp_resume got req=%b addr=%h want req=1 addr=1010", ifc.bus_req_valid, ifc.bus_req_addr);
      end
   endtask

   task automatic test_req_stall();
      int base, bad;
      mem_lat = 1; ifc.bus_req_ready = 1'b0;
      apply_reset(0);
      bad = 0;
      for (int i = 0; i < 2; i++) begin
         if (ifc.bus_req_valid !== 1'b1 || ifc.bus_req_addr !== ENTRY) bad++;
         tick();
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL stall_hold got bad=%0d want=0", bad);
      end
      base = n_consumed;
      do_redirect(64'h4000, 4);
      n_checks++;
      if (ifc.bus_req_valid !== 1'b1 || ifc.bus_req_addr !== 64'h4000) begin
         n_fail++;
         $display("FAIL stall_redirect got req=%b addr=%h want req=1 addr=4000", ifc.bus_req_valid, ifc.bus_req_addr);
      end
      tick();
      n_checks++;
      if (ifc.bus_req_valid !== 1'b1 || ifc.bus_req_addr !== 64'h4000) begin
         n_fail++;
         $display("FAIL stall_redirect_hold got req=%b addr=%h want req=1 addr=4000", ifc.bus_req_valid, ifc.bus_req_addr);
      end
      ifc.bus_req_ready = 1'b1;
      consume_until(base + 4);
   endtask

   task automatic test_reset_mid_wait();
      int base;
      mem_lat = 3; ifc.bus_req_ready = 1'b1;
      apply_reset(0);
      tick();
      reset = 1'b0;
      tick();
      n_checks++;
      if (ifc.bus_req_valid !== 1'b0 || ifc.bus_req_addr !== 64'h0 || ifc.instr_valid !== 1'b0 ||
          ifc.instruction !== 32'h0 || ifc.cur_pc !== 64'h0) begin
         n_fail++;
         $display("FAIL midwait_reset got req=%b addr=%h v=%b instr=%h pc=%h want all 0",
                  ifc.bus_req_valid, ifc.bus_req_addr, ifc.instr_valid, ifc.instruction, ifc.cur_pc);
      end
      base = n_consumed;
      apply_reset(4);
      n_checks++;
      if (ifc.bus_req_valid !== 1'b1 || ifc.bus_req_addr !== ENTRY) begin
         n_fail++;
         $display("FAIL midwait_restart got req=%b addr=%h want req=1 addr=%h", ifc.bus_req_valid, ifc.bus_req_addr, ENTRY);
      end
      consume_until(base + 4);
   endtask

   task automatic test_wrap();
      int base;
      mem_lat = 1; ifc.bus_req_ready = 1'b1;
      base = n_consumed;
      do_redirect(64'hFFFF_FFFF_FFFF_FFF8, 4);
      consume_until(base + 4);
   endtask

   initial begin
      reset = 1'b0;
      ifc.bus_req_ready  = 1'b0;
      ifc.redirect_valid = 1'b0;
      ifc.redirect_pc    = 64'h0;
      ifc.decode_ready   = 1'b0;
      test_reset();
      test_redirect_idle();
      test_redirect_wait();
      test_backpressure();
      test_req_stall();
      test_reset_mid_wait();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Fetch stage directly upstream of the decoder. It issues aligned 64-bit instruction-memory reads, splits each returned doubleword into two 32-bit RISC-V instructions, and buffers them with their PCs in a small FIFO. It presents one instruction and its PC per cycle to the decoder under a valid/ready handshake. It also accepts PC redirects from branch/jump resolution, flushing all in-flight and buffered instructions.

## Interface
- ENTRY_PC, 64'h0, PC fetched first after reset; must be 4-byte aligned.
- FIFO_DEPTH, 4, instruction buffer entries; power of two, minimum 2.
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low; state clears on a clk edge while reset==0.
- bus_req_valid  out  1  read request pending.
- bus_req_addr  out  64  doubleword-aligned read address, bits [2:0] = 0.
- bus_req_ready  in  1  memory accepts the request this cycle.
- bus_resp_valid  in  1  read data valid; exactly one response per accepted request, in order.
- bus_resp_data  in  64  [31:0] = instruction at addr, [63:32] = instruction at addr+4.
- redirect_valid  in  1  taken branch/jump; single-cycle pulse.
- redirect_pc  in  64  new fetch PC, 4-byte aligned.
- instr_valid  out  1  instruction/cur_pc valid for the decoder.
- instruction  out  32  instruction word; forced to 32'h0 when instr_valid==0.
- cur_pc  out  64  PC of instruction.
- decode_ready  in  1  decoder consumes the head this cycle.

## Operation
- FSM states: REQ (bus_req_valid=1), WAIT (request accepted, awaiting response), DRAIN (discard one stale response), IDLE (FIFO lacks space).
- Reset values: state=REQ on the first cycle after reset deasserts. fetch_pc=ENTRY_PC. FIFO empty. bus_req_valid=0, bus_req_addr=0, instr_valid=0, instruction=0, cur_pc=0.
- bus_req_addr = {fetch_pc[63:3], 3'b000}. The address is held stable while bus_req_valid && !bus_req_ready.
- Only one request is outstanding at a time. REQ→WAIT on bus_req_valid && bus_req_ready.
- REQ is entered only when free slots ≥ 2. Otherwise the FSM waits in IDLE, which moves to REQ as soon as free ≥ 2.
- Response in WAIT:
  - If fetch_pc[2]==0, push {fetch_pc, data[31:0]} then {fetch_pc+4, data[63:32]}; fetch_pc += 8.
  - If fetch_pc[2]==1, the low word is discarded; push {fetch_pc, data[63:32]} only; fetch_pc += 4.
  - After the push, go to REQ if free ≥ 2 after the push and pop, else IDLE.
- Pop occurs when instr_valid && decode_ready. The FIFO supports push of up to two entries and one pop in the same cycle.
- Redirect takes priority over any same-cycle push, pop or request acceptance:
  - FIFO is flushed; fetch_pc = redirect_pc.
  - If a request is outstanding, or is accepted in the same cycle, next state is DRAIN; otherwise REQ.
  - DRAIN drops the next response, then goes to REQ.
  - A response arriving in the redirect cycle itself counts as the outstanding one and is dropped; the FSM then goes to REQ, not DRAIN.
- A redirect during DRAIN updates fetch_pc and stays in DRAIN.
- A response arriving outside WAIT/DRAIN is a protocol error: ignored, with a simulation-only $error.
- PC arithmetic is 64-bit unsigned and wraps at 2^64 without a flag.

## Timing
- Request-to-instruction latency: a response in cycle N makes instr_valid=1 at N+1. The head is a registered output.
- A redirect in cycle N forces instr_valid=0 at N+1. The earliest new request is bus_req_valid=1 at N+1 from REQ, or the cycle after the stale response from DRAIN.
- Throughput: one doubleword per 2 cycles with a zero-wait memory, i.e. one instruction per cycle sustained.
- A full FIFO with decode_ready=0 holds instr_valid/instruction/cur_pc stable indefinitely.
- Reset asserted mid-request abandons the outstanding request. The memory side is reset together with this block.

## Structure
- Shared package fetch_pkg: fetch_state_e enum {REQ, WAIT, DRAIN, IDLE}, fetch_entry_t struct {pc[63:0], instr[31:0]}, localparam INSTR_BYTES=4, DWORD_BYTES=8.
- Sub-module fetch_fifo: parameterised depth, 2-wide push, 1-wide pop, flush, count output. The FSM and PC logic stay in instr_fetch.

## Test plan
- Reset with ENTRY_PC=0x1000, zero-wait memory returning {0x00500093, 0x00000013}:
  - bus_req_addr=0x1000;
  - the decoder sees 0x00000013 @0x1000, then 0x00500093 @0x1004, on consecutive cycles;
  - instruction=0 before the first valid.
- Redirect to 0x2004 while idle: request addr=0x2000; only data[63:32] is delivered, with cur_pc=0x2004; next request addr=0x2008.
- Redirect while WAIT at 0x1008: the response for 0x1008 is discarded; the first delivered instruction has cur_pc=redirect_pc; FIFO count=0 the cycle after the redirect.
- decode_ready=0 for 20 cycles, FIFO_DEPTH=4: exactly two requests are issued; outputs hold 0x1000's instruction; bus_req_valid stays 0 until a pop frees 2 slots.
- bus_req_ready held low 5 cycles: bus_req_addr stable throughout; a redirect in cycle 3 changes the address the next cycle with no DRAIN.
- Reset pulled low while in WAIT: all outputs zero next cycle; after release, fetch restarts at ENTRY_PC.
